// File: rtl/alu_share_arbiter_pkg.sv
// Shared definitions for the ALU share arbiter: FSM encodings, operand-select
// constants and the round-robin pick helper.
package alu_share_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } arb_state_e;

  localparam logic SEL_REQ0 = 1'b0;
  localparam logic SEL_REQ1 = 1'b1;

  // A tie goes to whichever requester did not own the ALU last.
  function automatic logic pick_next(input logic r0, input logic r1, input logic last);
    if (r0 && r1) begin
      return ~last;
    end else if (r1) begin
      return SEL_REQ1;
    end
    return SEL_REQ0;
  endfunction

endpackage

// File: rtl/operand_mux_2_1_w.sv
// WIDTH-bit 2:1 operand mux, built from one single-bit select cell per bit.
module operand_mux_2_1_w #(
  parameter int WIDTH = 16
) (
  input  logic             sel,
  input  logic [WIDTH-1:0] in_0,
  input  logic [WIDTH-1:0] in_1,
  output logic [WIDTH-1:0] out
);

  genvar i;
  generate
    for (i = 0; i < WIDTH; i++) begin : g_bit
      assign out[i] = sel ? in_1[i] : in_0[i];
    end
  endgenerate

endmodule

// File: rtl/alu_share_arbiter.sv
// Round-robin owner of one fixed-latency ALU shared by two requesters.
// Handshake: req_x is held until done_x; done_x is a 1-cycle pulse carrying result.
module alu_share_arbiter
  import alu_share_arbiter_pkg::*;
#(
  parameter int WIDTH   = 16,
  parameter int ALU_LAT = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_0,
  input  logic             req_1,
  input  logic [WIDTH-1:0] a_0,
  input  logic [WIDTH-1:0] b_0,
  input  logic [WIDTH-1:0] a_1,
  input  logic [WIDTH-1:0] b_1,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic             alu_start,
  input  logic [WIDTH-1:0] alu_result,
  output logic             sel,
  output logic             grant_0,
  output logic             grant_1,
  output logic             done_0,
  output logic             done_1,
  output logic [WIDTH-1:0] result,
  output logic             busy,
  output logic [1:0]       dbg_state
);

  localparam int CNT_W = $clog2(ALU_LAT + 1);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(ALU_LAT);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  arb_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             sel_q, sel_d;
  logic             last_grant_q, last_grant_d;
  logic [WIDTH-1:0] alu_a_q, alu_b_q;
  logic [WIDTH-1:0] result_q, result_d;
  logic [WIDTH-1:0] mux_a, mux_b;
  logic             grant_ev;

  // The muxes follow the next-sel value so the operands latch on the grant edge.
  operand_mux_2_1_w #(.WIDTH(WIDTH)) u_mux_a (
    .sel  (sel_d),
    .in_0 (a_0),
    .in_1 (a_1),
    .out  (mux_a)
  );

  operand_mux_2_1_w #(.WIDTH(WIDTH)) u_mux_b (
    .sel  (sel_d),
    .in_0 (b_0),
    .in_1 (b_1),
    .out  (mux_b)
  );

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    sel_d        = sel_q;
    last_grant_d = last_grant_q;
    result_d     = result_q;
    grant_ev     = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (req_0 || req_1) begin
          grant_ev     = 1'b1;
          sel_d        = pick_next(req_0, req_1, last_grant_q);
          last_grant_d = sel_d;
          cnt_d        = CNT_LOAD;
          state_d      = ST_BUSY;
        end
      end
      ST_BUSY: begin
        // The ALU result is valid in the cycle the counter reaches zero.
        if (cnt_q == '0) begin
          result_d = alu_result;
          state_d  = ST_DONE;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      sel_q        <= SEL_REQ0;
      last_grant_q <= SEL_REQ1;
      alu_a_q      <= '0;
      alu_b_q      <= '0;
      result_q     <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      sel_q        <= sel_d;
      last_grant_q <= last_grant_d;
      result_q     <= result_d;
      if (grant_ev) begin
        alu_a_q <= mux_a;
        alu_b_q <= mux_b;
      end
    end
  end

  // Owner-qualified outputs decode from state and the held select.
  assign busy      = (state_q != ST_IDLE);
  assign alu_start = (state_q == ST_BUSY) && (cnt_q == CNT_LOAD);
  assign grant_0   = busy && (sel_q == SEL_REQ0);
  assign grant_1   = busy && (sel_q == SEL_REQ1);
  assign done_0    = (state_q == ST_DONE) && (sel_q == SEL_REQ0);
  assign done_1    = (state_q == ST_DONE) && (sel_q == SEL_REQ1);
  assign sel       = sel_q;
  assign alu_a     = alu_a_q;
  assign alu_b     = alu_b_q;
  assign result    = result_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Directed bench for alu_share_arbiter: one instance at ALU_LAT=3, one at ALU_LAT=1.
module tb_alu_share_arbiter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  int          cyc = 0;
  int          n_checks = 0;
  int          n_pass = 0;

  // ---------------- instance 0 (ALU_LAT = 3)
  logic        req_0 = 0, req_1 = 0;
  logic [15:0] a_0 = 0, b_0 = 0, a_1 = 0, b_1 = 0;
  logic [15:0] alu_a, alu_b, alu_result, result;
  logic        alu_start, sel, grant_0, grant_1, done_0, done_1, busy;
  logic [1:0]  dbg_state;

  // ---------------- instance 1 (ALU_LAT = 1)
  logic        l1_req_0 = 0, l1_req_1 = 0;
  logic [15:0] l1_a_0 = 0, l1_b_0 = 0, l1_a_1 = 0, l1_b_1 = 0;
  logic [15:0] l1_alu_a, l1_alu_b, l1_alu_result, l1_result;
  logic        l1_alu_start, l1_sel, l1_grant_0, l1_grant_1, l1_done_0, l1_done_1, l1_busy;
  logic [1:0]  l1_dbg_state;

  logic [16:0] exp_q0[$];
  logic [16:0] exp_q1[$];

  alu_share_arbiter #(.WIDTH(16), .ALU_LAT(3)) u_dut (
    .clk(clk), .rst_n(rst_n), .req_0(req_0), .req_1(req_1),
    .a_0(a_0), .b_0(b_0), .a_1(a_1), .b_1(b_1),
    .alu_a(alu_a), .alu_b(alu_b), .alu_start(alu_start), .alu_result(alu_result),
    .sel(sel), .grant_0(grant_0), .grant_1(grant_1), .done_0(done_0), .done_1(done_1),
    .result(result), .busy(busy), .dbg_state(dbg_state)
  );

  alu_share_arbiter #(.WIDTH(16), .ALU_LAT(1)) u_dut_l1 (
    .clk(clk), .rst_n(rst_n), .req_0(l1_req_0), .req_1(l1_req_1),
    .a_0(l1_a_0), .b_0(l1_b_0), .a_1(l1_a_1), .b_1(l1_b_1),
    .alu_a(l1_alu_a), .alu_b(l1_alu_b), .alu_start(l1_alu_start), .alu_result(l1_alu_result),
    .sel(l1_sel), .grant_0(l1_grant_0), .grant_1(l1_grant_1), .done_0(l1_done_0),
    .done_1(l1_done_1), .result(l1_result), .busy(l1_busy), .dbg_state(l1_dbg_state)
  );

  // ---------------- clock / cycle counter
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- adder ALU models; garbage outside the valid slot
  logic [15:0] pipe0 [3];
  logic [15:0] pipe1;
  always @(posedge clk) begin
    pipe0[0] <= alu_start ? alu_a + alu_b : 16'hDEAD;
    pipe0[1] <= pipe0[0];
    pipe0[2] <= pipe0[1];
    pipe1    <= l1_alu_start ? l1_alu_a + l1_alu_b : 16'hBEEF;
  end
  assign alu_result    = pipe0[2];
  assign l1_alu_result = pipe1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
  endtask

  // ---------------- scoreboard monitors
  always @(negedge clk) begin
    if (rst_n) begin
      if (grant_0 && grant_1) check("grant_excl", 1, 0);
      if (done_0 || done_1) begin
        if (exp_q0.size() == 0) begin
          check("unexpected_done", {done_1, result}, 17'h0);
        end else begin
          logic [16:0] e;
          e = exp_q0.pop_front();
          check("done_owner", {done_1, done_0}, e[16] ? 2'b10 : 2'b01);
          check("done_result", result, e[15:0]);
        end
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n && (l1_done_0 || l1_done_1)) begin
      if (exp_q1.size() == 0) begin
        check("l1_unexpected_done", {l1_done_1, l1_result}, 17'h0);
      end else begin
        logic [16:0] e;
        e = exp_q1.pop_front();
        check("l1_done_owner", {l1_done_1, l1_done_0}, e[16] ? 2'b10 : 2'b01);
        check("l1_done_result", l1_result, e[15:0]);
      end
    end
  end

  // ---------------- driver tasks
  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  // ---------------- stimulus
  initial begin : stim
    int t0, start_at, done_at, d0_at, d1_at, ns, nd0, nd1, g1_seen, busy_cnt;
    logic sels [4];

    // Test 1: single request, add 5+7
    do_reset();
    check("reset_outputs", {alu_a, alu_b, result, alu_start, sel, grant_0, grant_1,
                            done_0, done_1, busy, dbg_state}, 64'h0);
    req_0 = 1; a_0 = 16'd5; b_0 = 16'd7;
    exp_q0.push_back({1'b0, 16'd12});
    t0 = cyc; start_at = -1; done_at = -1; g1_seen = 0;
    for (int i = 0; i < 20 && done_at < 0; i++) begin
      @(negedge clk);
      if (alu_start && start_at < 0) start_at = cyc - t0;
      if (grant_1) g1_seen = 1;
      if (done_0) done_at = cyc - t0;
    end
    req_0 = 0;
    check("t1_start_cycle", start_at, 1);
    check("t1_done_cycle", done_at, 5);
    check("t1_grant1_seen", g1_seen, 0);

    // Test 2: simultaneous requests, two ops each -> 0,1,0,1
    do_reset();
    req_0 = 1; req_1 = 1; a_0 = 16'd1; b_0 = 16'd2; a_1 = 16'd10; b_1 = 16'd20;
    exp_q0.push_back({1'b0, 16'd3});
    exp_q0.push_back({1'b1, 16'd30});
    exp_q0.push_back({1'b0, 16'd3});
    exp_q0.push_back({1'b1, 16'd30});
    ns = 0; nd0 = 0; nd1 = 0;
    for (int i = 0; i < 60 && (nd0 < 2 || nd1 < 2); i++) begin
      @(negedge clk);
      if (alu_start) begin
        if (ns < 4) sels[ns] = sel;
        ns++;
      end
      if (done_0) begin nd0++; if (nd0 == 2) req_0 = 0; end
      if (done_1) begin nd1++; if (nd1 == 2) req_1 = 0; end
    end
    req_0 = 0; req_1 = 0;
    check("t2_start_count", ns, 4);
    for (int k = 0; k < 4; k++) check("t2_sel_order", sels[k], k % 2);

    // Test 3: req_1 arrives during requester 0's BUSY
    do_reset();
    req_0 = 1; a_0 = 16'd3; b_0 = 16'd4;
    exp_q0.push_back({1'b0, 16'd7});
    exp_q0.push_back({1'b1, 16'd101});
    t0 = cyc; ns = 0; d0_at = -1; d1_at = -1;
    for (int i = 0; i < 40 && d1_at < 0; i++) begin
      @(negedge clk);
      if (cyc - t0 == 2) begin req_1 = 1; a_1 = 16'd100; b_1 = 16'd1; end
      if (alu_start && d0_at < 0) ns++;
      if (done_0) begin d0_at = cyc - t0; req_0 = 0; end
      if (done_1) begin d1_at = cyc - t0; req_1 = 0; end
    end
    req_0 = 0; req_1 = 0;
    check("t3_single_start", ns, 1);
    check("t3_done0_cycle", d0_at, 5);
    check("t3_done1_cycle", d1_at, 11);

    // Test 4: reset pulled at cnt=1, then tie after release
    do_reset();
    req_0 = 1; req_1 = 1; a_0 = 16'd2; b_0 = 16'd2; a_1 = 16'd40; b_1 = 16'd2;
    // requester 0 wins the first tie out of reset; this op gets aborted
    t0 = cyc;
    while (cyc - t0 < 3) @(negedge clk);
    rst_n = 0;
    #1;
    check("t4_async_clear", {alu_a, alu_b, result, alu_start, sel, grant_0, grant_1,
                             done_0, done_1, busy, dbg_state}, 64'h0);
    @(negedge clk);
    rst_n = 1;
    exp_q0.push_back({1'b0, 16'd4});
    exp_q0.push_back({1'b1, 16'd42});
    ns = 0; nd0 = 0; nd1 = 0;
    for (int i = 0; i < 30 && (nd0 < 1 || nd1 < 1); i++) begin
      @(negedge clk);
      if (alu_start) begin
        if (ns < 4) sels[ns] = sel;
        ns++;
      end
      if (done_0) begin nd0++; req_0 = 0; end
      if (done_1) begin nd1++; req_1 = 0; end
    end
    req_0 = 0; req_1 = 0;
    check("t4_first_sel", sels[0], 0);
    check("t4_done_count", nd0 + nd1, 2);

    // Test 5: req_0 dropped mid-BUSY still completes
    do_reset();
    req_0 = 1; a_0 = 16'd9; b_0 = 16'd6;
    exp_q0.push_back({1'b0, 16'd15});
    t0 = cyc; done_at = -1;
    for (int i = 0; i < 20 && done_at < 0; i++) begin
      @(negedge clk);
      if (cyc - t0 == 2) req_0 = 0;
      if (done_0) done_at = cyc - t0;
    end
    check("t5_done_cycle", done_at, 5);
    busy_cnt = 0;
    repeat (4) begin
      @(negedge clk);
      if (busy) busy_cnt++;
    end
    check("t5_stays_idle", busy_cnt, 0);

    // Test 6: ALU_LAT=1 instance, FFFF+0001 wraps to 0
    do_reset();
    l1_req_1 = 1; l1_a_1 = 16'hFFFF; l1_b_1 = 16'h0001;
    exp_q1.push_back({1'b1, 16'h0000});
    t0 = cyc; start_at = -1; done_at = -1;
    for (int i = 0; i < 20 && done_at < 0; i++) begin
      @(negedge clk);
      if (l1_alu_start && start_at < 0) start_at = cyc - t0;
      if (l1_done_1) begin done_at = cyc - t0; l1_req_1 = 0; end
    end
    l1_req_1 = 0;
    check("t6_start_cycle", start_at, 1);
    check("t6_done_cycle", done_at, 3);

    repeat (3) @(negedge clk);
    check("q0_drained", exp_q0.size(), 0);
    check("q1_drained", exp_q1.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1);
  end

endmodule
